// File: rtl/mask_bram_reader_if.sv
// rtl/mask_bram_reader_if.sv - start/BRAM/FIFO signal bundle for mask_bram_reader; MASK_READER_COORD_EN widens out_din
interface mask_bram_reader_if #(
  parameter int REDUCED_WIDTH      = 640,
  parameter int REDUCED_HEIGHT     = 240,
  parameter int REDUCED_IMAGE_SIZE = REDUCED_WIDTH * REDUCED_HEIGHT
);
  localparam int ADDR_W = $clog2(REDUCED_IMAGE_SIZE);
`ifdef MASK_READER_COORD_EN
  localparam int DOUT_W = 8 + $clog2(REDUCED_WIDTH) + $clog2(REDUCED_HEIGHT);
`else
  localparam int DOUT_W = 8;
`endif

  logic              start;
  logic              hough_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              out_wr_en;
  logic [DOUT_W-1:0] out_din;
  logic              out_full;
  logic              busy;
  logic              done;

  modport master (
    input  start, hough_done, rd_data, out_full,
    output rd_addr, out_wr_en, out_din, busy, done
  );

  modport slave (
    output start, hough_done, rd_data, out_full,
    input  rd_addr, out_wr_en, out_din, busy, done
  );
endinterface

// File: rtl/mask_bram_reader.sv
// rtl/mask_bram_reader.sv - streams the full mask BRAM into a FIFO in raster order; MASK_READER_COORD_EN adds {y,x} to each byte
module mask_bram_reader #(
  parameter int REDUCED_WIDTH      = 640,
  parameter int REDUCED_HEIGHT     = 240,
  parameter int REDUCED_IMAGE_SIZE = REDUCED_WIDTH * REDUCED_HEIGHT
) (
  input  logic                clock,
  input  logic                reset,
  mask_bram_reader_if.master  bus
);
  localparam int AW = $clog2(REDUCED_IMAGE_SIZE);
  localparam logic [AW-1:0] ADDR_LAST = AW'(REDUCED_IMAGE_SIZE - 1);
`ifdef MASK_READER_COORD_EN
  localparam int XW = $clog2(REDUCED_WIDTH);
  localparam int YW = $clog2(REDUCED_HEIGHT);
  localparam int DW = 8 + XW + YW;
  localparam logic [XW-1:0] X_LAST = XW'(REDUCED_WIDTH - 1);
`else
  localparam int DW = 8;
`endif

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            inflight_q, inflight_d;
  logic            hold_vld_q, hold_vld_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic [DW-1:0]   land_word;

`ifdef MASK_READER_COORD_EN
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [XW+YW-1:0] coord_q, coord_d;
  // coord_q belongs to the read currently in flight, so it lines up with rd_data
  assign land_word = {coord_q, bus.rd_data};
`else
  assign land_word = bus.rd_data;
`endif

  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    inflight_d    = 1'b0;
    hold_vld_d    = hold_vld_q;
    hold_d        = hold_q;
    bus.out_wr_en = 1'b0;
    bus.out_din   = '0;
`ifdef MASK_READER_COORD_EN
    x_d     = x_q;
    y_d     = y_q;
    coord_d = coord_q;
`endif

    // A held byte always goes out before anything newer; reads stall while it waits
    if (hold_vld_q) begin
      if (!bus.out_full) begin
        bus.out_wr_en = 1'b1;
        bus.out_din   = hold_q;
        hold_vld_d    = 1'b0;
      end
    end else if (inflight_q) begin
      if (!bus.out_full) begin
        bus.out_wr_en = 1'b1;
        bus.out_din   = land_word;
      end else begin
        hold_vld_d = 1'b1;
        hold_d     = land_word;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rd_addr_d = '0;
          state_d   = READ;
`ifdef MASK_READER_COORD_EN
          x_d = '0;
          y_d = '0;
`endif
        end
      end
      READ: begin
        if (!hold_vld_q && !bus.out_full) begin
          inflight_d = 1'b1;
`ifdef MASK_READER_COORD_EN
          coord_d = {y_q, x_q};
`endif
          if (rd_addr_q == ADDR_LAST) begin
            state_d = DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
`ifdef MASK_READER_COORD_EN
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
`endif
          end
        end
      end
      DRAIN: begin
        // Look at next-cycle occupancy so done rises right after the final push
        if (!inflight_d && !hold_vld_d) state_d = DONE;
      end
      DONE: begin
        if (bus.hough_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
`ifdef MASK_READER_COORD_EN
      x_q     <= '0;
      y_q     <= '0;
      coord_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
`ifdef MASK_READER_COORD_EN
      x_q     <= x_d;
      y_q     <= y_d;
      coord_q <= coord_d;
`endif
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.busy    = (state_q == READ) || (state_q == DRAIN);
  assign bus.done    = (state_q == DONE);
endmodule
